carpool_merge_ctrl: RTL and testbench
=====================================

// Module: carpool_merge_ctrl
// PURPOSE
//  Merge-window scheduler in front of the carpool merge comparator in the router. Buffers up to one flit per input port.
//  Holds the flits for a programmable window so late arrivals can merge. Sequences one comparator evaluation, applies
//  the returned kill / srcList_new results, then issues the surviving flits per port with valid/ready.
// PARAMETERS
//  NUM_PORT   5   input/output ports (comparator fixed at 5)
//  SRC_W      5   srcList width per flit
//  ADDR_W     32  address/flowID width per flit
//  DST_W      4   destination width per flit
//  FID_W      3   flitID width per flit
//  WINDOW     2   COLLECT cycles after first arrival (0 = no wait)
//  CNT_W      16  merge statistics counter width
// PORTS
//  clk        in   1                clock
//  reset      in   1                synchronous, active-high reset
//  in_valid   in   NUM_PORT         per-port flit valid
//  in_ready   out  NUM_PORT         per-port slot free; accept = in_valid&in_ready
//  in_src     in   NUM_PORT*SRC_W   packed srcList, port p at [p*SRC_W +: SRC_W]
//  in_addr    in   NUM_PORT*ADDR_W  packed addr
//  in_dst     in   NUM_PORT*DST_W   packed dst
//  in_fid     in   NUM_PORT*FID_W   packed flitID
//  m_hs       out  NUM_PORT         to comparator hs_p; high only in MERGE
//  m_src/m_addr/m_dst/m_fid  out  packed  slot contents to comparator
//  m_kill     in   NUM_PORT         comparator kill
//  m_src_new  in   NUM_PORT*SRC_W   comparator srcList_new
//  out_valid  out  NUM_PORT         surviving flit valid (ISSUE only)
//  out_ready  in   NUM_PORT         switch accepts port p flit
//  out_src/out_addr/out_dst/out_fid  out  packed  slot contents
//  merge_cnt  out  CNT_W            total flits killed by merge, saturating
// BEHAVIOUR
//  - Reset (sync, cycle after reset high): state=IDLE, slot_v=0, window counter=0, merge_cnt=0.
//    Outputs during reset: out_valid=0, m_hs=0, in_ready=0. Slot data is don't-care.
//  - in_ready[p] = ~reset & ~slot_v[p] & (state==IDLE|COLLECT). An accepted flit is written to slot p at the clock edge.
//  - IDLE: if any accept occurs, go to MERGE when all slots are full after the accept or WINDOW==0; otherwise go to COLLECT with cnt=WINDOW.
//  - COLLECT: accept into empty slots; cnt--. Go to MERGE when cnt==1 or all slots are full after this cycle's accepts.
//  - MERGE (exactly 1 cycle): m_hs=slot_v. At the edge: slot_v &= ~m_kill; src[p] <= m_src_new[p] for surviving slots.
//    merge_cnt += popcount(m_kill&slot_v), saturating at 2^CNT_W-1. m_kill on an empty slot is ignored. Go to ISSUE.
//  - ISSUE: out_valid=slot_v. Slot p clears on out_valid[p]&out_ready[p]. Ports drain independently, any order.
//    out_ready on an invalid port is ignored. When slot_v becomes 0 go to IDLE; in_ready rises the next cycle.
//    If all slots are killed except none (slot_v=0 after MERGE), ISSUE lasts 1 cycle with out_valid=0.
//  - Latency: first accept in cycle c -> earliest out_valid at c+WINDOW+2 (c+2 when all ports arrive at once).
//  - Data is stable while out_valid is high. No new flits are accepted in MERGE/ISSUE; the upstream holds in_valid.
//  - Reset mid-operation: all held flits are dropped; no out_valid in the following cycle.
// TESTING
//  1. WINDOW=2, c0: ports 0,3 same addr/dst/fid, src 5'b00001/5'b01000 -> m_hs=5'b01001 @c3;
//     out_valid=5'b00001 @c4; out_src[0]=5'b01001; merge_cnt=1.
//  2. port1 @c0, port2 @c2 -> both held (in_ready[2]=1 @c2); port4 valid @c3 -> in_ready[4]=0 until IDLE.
//  3. all 5 ports valid @c0, WINDOW=2 -> MERGE @c1 (window skipped), out_valid @c2.
//  4. ISSUE with 3 survivors, out_ready[2]=0 for 3 cycles -> others clear; state stays ISSUE; IDLE 1 cycle after port2 accept.
//  5. reset high during COLLECT -> next cycle out_valid=0, in_ready=0, merge_cnt=0; after release in_ready=5'b11111.
//  6. CNT_W=4, 16 killed flits across bursts -> merge_cnt saturates at 15, does not wrap.

Source files
------------

// File: rtl/carpool_merge_ctrl.sv
// carpool_merge_ctrl: merge-window scheduler; in_* collect one flit per port, m_* drive/return the merge comparator, out_* issue survivors, merge_cnt counts killed flits
module carpool_merge_ctrl #(
    parameter int NUM_PORT = 5,
    parameter int SRC_W    = 5,
    parameter int ADDR_W   = 32,
    parameter int DST_W    = 4,
    parameter int FID_W    = 3,
    parameter int WINDOW   = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORT-1:0]        in_valid,
    output logic [NUM_PORT-1:0]        in_ready,
    input  logic [NUM_PORT*SRC_W-1:0]  in_src,
    input  logic [NUM_PORT*ADDR_W-1:0] in_addr,
    input  logic [NUM_PORT*DST_W-1:0]  in_dst,
    input  logic [NUM_PORT*FID_W-1:0]  in_fid,
    output logic [NUM_PORT-1:0]        m_hs,
    output logic [NUM_PORT*SRC_W-1:0]  m_src,
    output logic [NUM_PORT*ADDR_W-1:0] m_addr,
    output logic [NUM_PORT*DST_W-1:0]  m_dst,
    output logic [NUM_PORT*FID_W-1:0]  m_fid,
    input  logic [NUM_PORT-1:0]        m_kill,
    input  logic [NUM_PORT*SRC_W-1:0]  m_src_new,
    output logic [NUM_PORT-1:0]        out_valid,
    input  logic [NUM_PORT-1:0]        out_ready,
    output logic [NUM_PORT*SRC_W-1:0]  out_src,
    output logic [NUM_PORT*ADDR_W-1:0] out_addr,
    output logic [NUM_PORT*DST_W-1:0]  out_dst,
    output logic [NUM_PORT*FID_W-1:0]  out_fid,
    output logic [CNT_W-1:0]           merge_cnt
);
    localparam int CW = WINDOW > 0 ? $clog2(WINDOW + 1) : 1;
    localparam int KW = $clog2(NUM_PORT + 1);
    typedef enum logic [1:0] {IDLE, COLLECT, MERGE, ISSUE} state_t;
    state_t state, state_nx;
    logic [NUM_PORT-1:0] slot_v, slot_nx, acc, kill;
    logic [CW-1:0] cnt, cnt_nx;
    logic [KW-1:0] kcnt;
    logic [CNT_W:0] msum;
    logic [NUM_PORT*SRC_W-1:0] src_q;
    logic [NUM_PORT*ADDR_W-1:0] addr_q;
    logic [NUM_PORT*DST_W-1:0] dst_q;
    logic [NUM_PORT*FID_W-1:0] fid_q;
    logic open;
    assign open = state == IDLE || state == COLLECT;
    assign in_ready = {NUM_PORT{~reset & open}} & ~slot_v;
    assign acc = in_valid & in_ready;
    assign kill = m_kill & slot_v;
    assign m_hs = (!reset && state == MERGE) ? slot_v : '0;
    assign out_valid = (!reset && state == ISSUE) ? slot_v : '0;
    assign {m_src, out_src} = {src_q, src_q};
    assign {m_addr, out_addr} = {addr_q, addr_q};
    assign {m_dst, out_dst} = {dst_q, dst_q};
    assign {m_fid, out_fid} = {fid_q, fid_q};
    assign msum = {1'b0, merge_cnt} + (CNT_W + 1)'(kcnt);
    always_comb begin
        kcnt = '0;
        for (int i = 0; i < NUM_PORT; i++) kcnt = kcnt + KW'(kill[i]);
    end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        slot_nx = slot_v;
        case (state)
            IDLE: begin
                slot_nx = slot_v | acc;
                cnt_nx = CW'(WINDOW);
                state_nx = !(|acc) ? IDLE : (&slot_nx || WINDOW == 0) ? MERGE : COLLECT;
            end
            COLLECT: begin
                slot_nx = slot_v | acc;
                cnt_nx = cnt - CW'(1);
                state_nx = (cnt == CW'(1) || &slot_nx) ? MERGE : COLLECT;
            end
            MERGE: begin
                slot_nx = slot_v & ~m_kill;
                state_nx = ISSUE;
            end
            default: begin
                slot_nx = slot_v & ~out_ready;
                state_nx = |slot_nx ? ISSUE : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            slot_v <= '0;
            cnt <= '0;
            merge_cnt <= '0;
        end else begin
            state <= state_nx;
            slot_v <= slot_nx;
            cnt <= cnt_nx;
            if (state == MERGE) merge_cnt <= msum[CNT_W] ? '1 : msum[CNT_W-1:0];
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORT; i++) begin
            if (acc[i]) begin
                src_q[i*SRC_W +: SRC_W] <= in_src[i*SRC_W +: SRC_W];
                addr_q[i*ADDR_W +: ADDR_W] <= in_addr[i*ADDR_W +: ADDR_W];
                dst_q[i*DST_W +: DST_W] <= in_dst[i*DST_W +: DST_W];
                fid_q[i*FID_W +: FID_W] <= in_fid[i*FID_W +: FID_W];
            end else if (state == MERGE && slot_v[i] && !m_kill[i]) begin
                src_q[i*SRC_W +: SRC_W] <= m_src_new[i*SRC_W +: SRC_W];
            end
        end
    end
endmodule

// File: tb/tb_carpool_merge_ctrl.sv
// tb_carpool_merge_ctrl: randomized and directed checks of carpool_merge_ctrl against a cycle-number based batch model
module tb_carpool_merge_ctrl;
    localparam int NP = 5, SW = 5, AW = 32, DW = 4, FW = 3, WIN = 2, CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 0, reset = 1;
    logic [NP-1:0] in_valid = '0, in_ready, m_hs, m_kill = '0, out_valid, out_ready = '0;
    logic [NP*SW-1:0] in_src = '0, m_src, m_src_new = '0, out_src;
    logic [NP*AW-1:0] in_addr = '0, m_addr, out_addr;
    logic [NP*DW-1:0] in_dst = '0, m_dst, out_dst;
    logic [NP*FW-1:0] in_fid = '0, m_fid, out_fid;
    logic [CW-1:0] merge_cnt;
    int checks = 0, errors = 0;
    bit chk_en = 0;
    carpool_merge_ctrl #(.NUM_PORT(NP), .SRC_W(SW), .ADDR_W(AW), .DST_W(DW), .FID_W(FW),
                         .WINDOW(WIN), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_addr(in_addr), .in_dst(in_dst), .in_fid(in_fid),
        .m_hs(m_hs), .m_src(m_src), .m_addr(m_addr), .m_dst(m_dst), .m_fid(m_fid),
        .m_kill(m_kill), .m_src_new(m_src_new), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .out_addr(out_addr), .out_dst(out_dst), .out_fid(out_fid),
        .merge_cnt(merge_cnt)
    );
    always #5 clk = ~clk;
    // model: held flits plus the cycle number at which the current batch is merged
    logic [NP-1:0] hv = '0, macc;
    logic [SW-1:0] hsrc[NP];
    logic [AW-1:0] haddr[NP];
    logic [DW-1:0] hdst[NP];
    logic [FW-1:0] hfid[NP];
    int cyc = 0, mcyc = -1, mc = 0;
    bit drain = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask
    task automatic model_step();
        if (reset) begin
            hv = '0;
            mcyc = -1;
            drain = 0;
            mc = 0;
        end else if (mcyc == cyc) begin
            for (int p = 0; p < NP; p++)
                if (hv[p]) begin
                    if (m_kill[p]) mc = mc < CMAX ? mc + 1 : CMAX;
                    else hsrc[p] = m_src_new[p*SW +: SW];
                end
            hv = hv & ~m_kill;
            drain = 1;
            mcyc = -1;
        end else if (drain) begin
            hv = hv & ~out_ready;
            if (hv == '0) drain = 0;
        end else begin
            macc = in_valid & ~hv;
            for (int p = 0; p < NP; p++)
                if (macc[p]) begin
                    hsrc[p] = in_src[p*SW +: SW];
                    haddr[p] = in_addr[p*AW +: AW];
                    hdst[p] = in_dst[p*DW +: DW];
                    hfid[p] = in_fid[p*FW +: FW];
                end
            if (macc != '0 && mcyc < 0) mcyc = cyc + WIN + 1;
            if (macc != '0 && &(hv | macc)) mcyc = cyc + 1;
            hv = hv | macc;
        end
        cyc++;
    endtask
    task automatic compare();
        logic [NP-1:0] e_rdy, e_hs, e_ov;
        e_rdy = (reset || drain || mcyc == cyc) ? '0 : ~hv;
        e_hs = (!reset && mcyc == cyc) ? hv : '0;
        e_ov = (!reset && drain) ? hv : '0;
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("m_hs", 64'(m_hs), 64'(e_hs));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("merge_cnt", 64'(merge_cnt), 64'(mc));
        for (int p = 0; p < NP; p++) begin
            if (e_hs[p]) begin
                chk("m_src", 64'(m_src[p*SW +: SW]), 64'(hsrc[p]));
                chk("m_addr", 64'(m_addr[p*AW +: AW]), 64'(haddr[p]));
                chk("m_dst_fid", 64'({m_dst[p*DW +: DW], m_fid[p*FW +: FW]}), 64'({hdst[p], hfid[p]}));
            end
            if (e_ov[p]) begin
                chk("out_src", 64'(out_src[p*SW +: SW]), 64'(hsrc[p]));
                chk("out_addr", 64'(out_addr[p*AW +: AW]), 64'(haddr[p]));
                chk("out_dst_fid", 64'({out_dst[p*DW +: DW], out_fid[p*FW +: FW]}), 64'({hdst[p], hfid[p]}));
            end
        end
    endtask
    initial forever begin
        @(posedge clk);
        model_step();
    end
    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        step();
        chk_en = 1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        step();
        reset = 0;
        #1;
        chk("rst_merge_cnt", 64'(merge_cnt), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'h1f);
        // ports 0 and 3 carry the same flow; comparator keeps port 0 with the merged srcList
        in_valid = 5'b01001;
        in_src = '0;
        in_src[4:0] = 5'b00001;
        in_src[19:15] = 5'b01000;
        in_addr[31:0] = 32'hcafe0001;
        in_addr[127:96] = 32'hcafe0001;
        step();
        in_valid = '0;
        step();
        step();
        chk("t1_m_hs_c3", 64'(m_hs), 64'h09);
        m_kill = 5'b01000;
        m_src_new = '0;
        m_src_new[4:0] = 5'b01001;
        step();
        m_kill = '0;
        chk("t1_out_valid_c4", 64'(out_valid), 64'h01);
        chk("t1_out_src0", 64'(out_src[4:0]), 64'h09);
        chk("t1_out_addr0", 64'(out_addr[31:0]), 64'hcafe0001);
        chk("t1_merge_cnt", 64'(merge_cnt), 64'd1);
        out_ready = 5'b11111;
        step();
        chk("t1_idle_out_valid", 64'(out_valid), 64'd0);
        chk("t1_idle_in_ready", 64'(in_ready), 64'h1f);
        out_ready = '0;
        in_valid = 5'b00010;
        step();
        in_valid = '0;
        step();
        in_valid = 5'b00100;
        chk("t2_late_ready", 64'(in_ready), 64'h1d);
        step();
        in_valid = 5'b10000;
        chk("t2_merge_in_ready", 64'(in_ready), 64'd0);
        chk("t2_m_hs", 64'(m_hs), 64'h06);
        step();
        chk("t2_issue_in_ready", 64'(in_ready), 64'd0);
        chk("t2_out_valid", 64'(out_valid), 64'h06);
        out_ready = 5'b11111;
        step();
        chk("t2_idle_in_ready", 64'(in_ready), 64'h1f);
        step();
        in_valid = '0;
        repeat (5) step();
        chk("t2_drained", 64'(in_ready), 64'h1f);
        out_ready = '0;
        in_valid = 5'b11111;
        step();
        chk("t3_m_hs_c1", 64'(m_hs), 64'h1f);
        in_valid = '0;
        m_kill = 5'b10001;
        step();
        m_kill = '0;
        chk("t3_out_valid_c2", 64'(out_valid), 64'h0e);
        chk("t3_merge_cnt", 64'(merge_cnt), 64'd3);
        out_ready = 5'b11011;
        repeat (3) step();
        chk("t4_held_port2", 64'(out_valid), 64'h04);
        chk("t4_still_issue", 64'(in_ready), 64'd0);
        out_ready = 5'b00100;
        step();
        chk("t4_idle_out_valid", 64'(out_valid), 64'd0);
        chk("t4_idle_in_ready", 64'(in_ready), 64'h1f);
        out_ready = '0;
        in_valid = 5'b00001;
        step();
        in_valid = '0;
        reset = 1;
        #1;
        chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_merge_cnt", 64'(merge_cnt), 64'd0);
        reset = 0;
        #1;
        chk("t5_release_ready", 64'(in_ready), 64'h1f);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 5'b11111;
            step();
            in_valid = '0;
            m_kill = 5'b11111;
            step();
            m_kill = '0;
            chk("t6_all_killed_ov", 64'(out_valid), 64'd0);
            chk("t6_sat_cnt", 64'(merge_cnt), 64'(k * 5 > 15 ? 15 : k * 5));
            step();
        end
        repeat (3000) begin
            reset = $urandom_range(0, 249) == 0;
            in_valid = NP'($urandom) & NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                in_src[p*SW +: SW] = SW'($urandom);
                in_addr[p*AW +: AW] = $urandom;
                in_dst[p*DW +: DW] = DW'($urandom);
                in_fid[p*FW +: FW] = FW'($urandom);
                m_src_new[p*SW +: SW] = SW'($urandom);
            end
            m_kill = NP'($urandom) & NP'($urandom) & NP'($urandom);
            out_ready = NP'($urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
